// File: rtl/input_sequencer_pkg.sv
// Shared definitions for the keypad input sequencer.
//   - key code constants (no-request, operators, equals, clear, digit base)
//   - sequencer state encoding
//   - default widths and small code-classification helpers
package input_sequencer_pkg;

  localparam int unsigned IcNDefault = 5;
  localparam int unsigned CdNDefault = 32;

  localparam int unsigned CmdNon   = 32'h00;
  localparam int unsigned CmdAdd   = 32'h01;
  localparam int unsigned CmdSub   = 32'h02;
  localparam int unsigned CmdMul   = 32'h03;
  localparam int unsigned CmdDiv   = 32'h04;
  localparam int unsigned CmdLpar  = 32'h05;
  localparam int unsigned CmdRpar  = 32'h06;
  localparam int unsigned CmdEqu   = 32'h08;
  localparam int unsigned CmdClr   = 32'h0F;
  localparam int unsigned CmdDigit = 32'h10;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StIssue,
    StRelease
  } seq_state_e;

  // Codes that are forwarded to the core.
  function automatic logic is_issue_code(input int unsigned code);
    return ((code >= CmdAdd) && (code <= CmdRpar)) || (code == CmdEqu) || (code == CmdClr);
  endfunction

  function automatic logic is_digit_code(input int unsigned code);
    return (code >= CmdDigit) && (code <= CmdDigit + 9);
  endfunction

endpackage

// File: rtl/input_sequencer_digit_mac.sv
// Operand accumulate step: result = num*10 + digit, saturating.
//   num    : current operand (CD_N bits, unsigned)
//   digit  : decimal digit 0..9
//   result : next operand, clamped to 2^CD_N-1
//   ovf    : high when the clamp was applied
module digit_mac
  import input_sequencer_pkg::*;
#(
  parameter int unsigned CD_N = CdNDefault
) (
  input  logic [CD_N-1:0] num,
  input  logic [3:0]      digit,
  output logic [CD_N-1:0] result,
  output logic            ovf
);

  localparam int unsigned WideW = CD_N + 4;

  logic [WideW-1:0] num_w;
  logic [WideW-1:0] wide;

  // Four extra bits cover the worst case (2^CD_N-1)*10+9.
  always_comb begin
    num_w  = {4'b0000, num};
    wide   = (num_w << 3) + (num_w << 1) + {{CD_N{1'b0}}, digit};
    ovf    = |wide[WideW-1:CD_N];
    result = ovf ? '1 : wide[CD_N-1:0];
  end

endmodule

// File: rtl/input_sequencer.sv
// Keypad front-end: runs the four-phase in_cmd/in_ack handshake, accumulates
// digit keys into an operand and forwards operator/equals/clear keys to the
// core over a req/ack handshake.
//   Clock, Reset        : clock, async active-low reset
//   in_cmd / in_ack     : keypad key code and acknowledge
//   core_req / core_ack : command valid to core / core accept
//   core_cmd            : latched key code
//   core_num            : accumulated operand
//   core_has_num        : at least one digit since last issue
//   num_ovf             : sticky operand saturation flag
//   busy                : sequencer not idle
module input_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int unsigned IC_N = IcNDefault,
  parameter int unsigned CD_N = CdNDefault
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [IC_N-1:0] in_cmd,
  output logic            in_ack,
  output logic            core_req,
  output logic [IC_N-1:0] core_cmd,
  output logic [CD_N-1:0] core_num,
  output logic            core_has_num,
  input  logic            core_ack,
  output logic            num_ovf,
  output logic            busy
);

  seq_state_e      state_q, state_d;
  logic [IC_N-1:0] cmd_q, cmd_d;
  logic [CD_N-1:0] num_q, num_d;
  logic            has_num_q, has_num_d;
  logic            ovf_q, ovf_d;
  logic            in_ack_q, in_ack_d;
  logic            core_req_q, core_req_d;
  logic            busy_q, busy_d;

  logic [3:0]      digit;
  logic [CD_N-1:0] mac_result;
  logic            mac_ovf;

  assign digit = 4'(cmd_q - IC_N'(CmdDigit));

  digit_mac #(
    .CD_N(CD_N)
  ) u_digit_mac (
    .num   (num_q),
    .digit (digit),
    .result(mac_result),
    .ovf   (mac_ovf)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    num_d      = num_q;
    has_num_d  = has_num_q;
    ovf_d      = ovf_q;
    in_ack_d   = 1'b0;
    core_req_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_cmd != '0) begin
          cmd_d   = in_cmd;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_digit_code(32'(cmd_q))) begin
          num_d     = mac_result;
          ovf_d     = ovf_q | mac_ovf;
          has_num_d = 1'b1;
          state_d   = StRelease;
        end else if (is_issue_code(32'(cmd_q))) begin
          state_d = StIssue;
        end else begin
          // Invalid code: acknowledge the keypad, but never reach the core.
          state_d = StRelease;
        end
      end
      StIssue: begin
        // Ack only counts once the request is actually visible to the core.
        if (core_req_q && core_ack) begin
          num_d     = '0;
          has_num_d = 1'b0;
          ovf_d     = 1'b0;
          state_d   = StRelease;
        end else begin
          core_req_d = 1'b1;
        end
      end
      StRelease: begin
        if (in_cmd == '0) begin
          state_d = StIdle;
        end else begin
          in_ack_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      cmd_q      <= IC_N'(CmdNon);
      num_q      <= '0;
      has_num_q  <= 1'b0;
      ovf_q      <= 1'b0;
      in_ack_q   <= 1'b0;
      core_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      num_q      <= num_d;
      has_num_q  <= has_num_d;
      ovf_q      <= ovf_d;
      in_ack_q   <= in_ack_d;
      core_req_q <= core_req_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ack       = in_ack_q;
  assign core_req     = core_req_q;
  assign core_cmd     = cmd_q;
  assign core_num     = num_q;
  assign core_has_num = has_num_q;
  assign num_ovf      = ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench: a 32-bit and an 8-bit operand instance share the same
// keypad/core stimulus; a decimal reference model tracks both operands.
module tb_input_sequencer;

  logic       Clock;
  logic       Reset;
  logic [4:0] in_cmd;
  logic       core_ack;

  logic        a_in_ack, a_req, a_has, a_ovf, a_busy;
  logic [4:0]  a_cmd;
  logic [31:0] a_num;
  logic        b_in_ack, b_req, b_has, b_ovf, b_busy;
  logic [4:0]  b_cmd;
  logic [7:0]  b_num;

  int nchk = 0;
  int nerr = 0;

  // Reference model: index 0 is the 32-bit instance, index 1 the 8-bit one.
  longint unsigned m_num[2];
  longint unsigned m_max[2];
  bit              m_ovf[2];
  bit              m_has;

  input_sequencer #(.IC_N(5), .CD_N(32)) dut_a (
    .Clock(Clock), .Reset(Reset), .in_cmd(in_cmd), .in_ack(a_in_ack),
    .core_req(a_req), .core_cmd(a_cmd), .core_num(a_num), .core_has_num(a_has),
    .core_ack(core_ack), .num_ovf(a_ovf), .busy(a_busy)
  );

  input_sequencer #(.IC_N(5), .CD_N(8)) dut_b (
    .Clock(Clock), .Reset(Reset), .in_cmd(in_cmd), .in_ack(b_in_ack),
    .core_req(b_req), .core_cmd(b_cmd), .core_num(b_num), .core_has_num(b_has),
    .core_ack(core_ack), .num_ovf(b_ovf), .busy(b_busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input bit ack, input bit req, input bit bsy);
    check({tag, "_in_ack_a"}, a_in_ack, ack);
    check({tag, "_in_ack_b"}, b_in_ack, ack);
    check({tag, "_req_a"}, a_req, req);
    check({tag, "_req_b"}, b_req, req);
    check({tag, "_busy_a"}, a_busy, bsy);
    check({tag, "_busy_b"}, b_busy, bsy);
  endtask

  task automatic chk_num(input string tag);
    check({tag, "_num_a"}, a_num, m_num[0]);
    check({tag, "_num_b"}, b_num, m_num[1]);
    check({tag, "_has_a"}, a_has, m_has);
    check({tag, "_has_b"}, b_has, m_has);
    check({tag, "_ovf_a"}, a_ovf, m_ovf[0]);
    check({tag, "_ovf_b"}, b_ovf, m_ovf[1]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_num[i] = 0;
      m_ovf[i] = 0;
    end
    m_has = 0;
  endtask

  task automatic model_digit(input int d);
    for (int i = 0; i < 2; i++) begin
      if (m_num[i] * 10 + longint'(d) > m_max[i]) begin
        m_num[i] = m_max[i];
        m_ovf[i] = 1;
      end else begin
        m_num[i] = m_num[i] * 10 + longint'(d);
      end
    end
    m_has = 1;
  endtask

  // One complete keypad transaction. hold: extra cycles key stays down after
  // in_ack; stall: cycles the core withholds core_ack.
  task automatic press(input logic [4:0] code, input int hold, input int stall);
    bit is_op;
    bit is_dig;
    is_op  = (code >= 5'h01 && code <= 5'h06) || code == 5'h08 || code == 5'h0F;
    is_dig = (code >= 5'h10 && code <= 5'h19);
    @(negedge Clock);
    in_cmd = code;
    @(negedge Clock);
    chk_hs("lat1", 1'b0, 1'b0, 1'b1);
    // Stray core acks outside an issue must have no effect.
    if (!is_op) core_ack = 1'($urandom_range(0, 1));
    @(negedge Clock);
    chk_hs("lat2", 1'b0, 1'b0, 1'b1);
    core_ack = 1'b0;
    if (is_dig) model_digit(int'(code) - 16);
    chk_num("acc");
    @(negedge Clock);
    if (is_op) begin
      chk_hs("issue", 1'b0, 1'b1, 1'b1);
      check("cmd_a", a_cmd, code);
      check("cmd_b", b_cmd, code);
      chk_num("issue");
      for (int i = 0; i < stall; i++) begin
        @(negedge Clock);
        chk_hs("stall", 1'b0, 1'b1, 1'b1);
        check("stall_cmd", a_cmd, code);
        check("stall_num", a_num, m_num[0]);
      end
      core_ack = 1'b1;
      @(negedge Clock);
      core_ack = 1'b0;
      model_clear();
      chk_hs("acked", 1'b0, 1'b0, 1'b1);
      chk_num("acked");
      @(negedge Clock);
    end
    chk_hs("rel", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      chk_hs("hold", 1'b1, 1'b0, 1'b1);
    end
    in_cmd = 5'h00;
    @(negedge Clock);
    chk_hs("idle", 1'b0, 1'b0, 1'b0);
    chk_num("idle");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_hs(tag, 1'b0, 1'b0, 1'b0);
    check({tag, "_cmd_a"}, a_cmd, 5'h00);
    check({tag, "_cmd_b"}, b_cmd, 5'h00);
    chk_num(tag);
  endtask

  initial begin
    logic [4:0] inv_codes[14];
    logic [4:0] code;
    int         r;

    inv_codes = '{5'h07, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E,
                  5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F, 5'h1C};
    m_max[0] = 64'h0000_0000_FFFF_FFFF;
    m_max[1] = 64'd255;
    model_clear();

    Reset    = 1'b0;
    in_cmd   = 5'h00;
    core_ack = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge Clock);
    Reset = 1'b1;

    // 1: 1,2,3 then ADD.
    press(5'h11, 0, 0);
    press(5'h12, 1, 0);
    press(5'h13, 0, 0);
    check("t1_num123", a_num, 64'd123);
    press(5'h01, 0, 2);

    // 2: 2,5,6 saturates the 8-bit operand; a further 7 leaves it at max.
    press(5'h12, 0, 0);
    press(5'h15, 0, 0);
    press(5'h16, 0, 0);
    check("t2_sat", b_num, 64'd255);
    check("t2_ovf", b_ovf, 1'b1);
    press(5'h17, 0, 0);
    check("t2_hold", b_num, 64'd255);
    press(5'h08, 0, 1);

    // 3: EQU with no digits, core stalls 20 cycles.
    press(5'h08, 0, 20);

    // 4: invalid code, then one digit key held for 50 cycles.
    press(5'h1C, 2, 0);
    press(5'h14, 50, 0);
    check("t4_one", a_num, 64'd4);

    // 5: async reset while a request is outstanding.
    @(negedge Clock);
    in_cmd = 5'h03;
    repeat (3) @(negedge Clock);
    check("t5_req", a_req, 1'b1);
    #2 Reset = 1'b0;
    #1 model_clear();
    chk_reset_outputs("t5_async");
    in_cmd = 5'h00;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk_reset_outputs("t5_after");

    // 6: CLR after 9,9.
    press(5'h19, 0, 0);
    press(5'h19, 0, 0);
    check("t6_num99", a_num, 64'd99);
    press(5'h0F, 0, 1);

    // Random key mix.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      code = 5'(16 + $urandom_range(0, 9));
      else if (r <= 6) code = 5'($urandom_range(1, 6));
      else if (r == 7) code = 5'h08;
      else if (r == 8) code = 5'h0F;
      else             code = inv_codes[$urandom_range(0, 13)];
      press(code, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
Name: input_sequencer

Overview:
Front-end controller between the keypad input interface and the calculator core. Runs the four-phase in_cmd/in_ack handshake and accumulates decimal digit keys into a binary operand register. Forwards each operator, equals or clear key, together with any pending operand, to the core over a req/ack handshake. It is the only block that drives in_ack, and it isolates the core from keypad timing.

Parameters:
IC_N, 5, input command width
CD_N, 32, operand (number) width in bits, unsigned

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
in_cmd  input  IC_N  key code from input interface; IC_NON (0) = no request
in_ack  output  1  handshake acknowledge to input interface
core_req  output  1  command valid to core
core_cmd  output  IC_N  latched command code
core_num  output  CD_N  accumulated operand
core_has_num  output  1  at least one digit entered since last issue/clear
core_ack  input  1  core accepted command (sampled while core_req=1)
num_ovf  output  1  sticky: operand saturated
busy  output  1  state != IDLE

Behaviour:
- All outputs registered. Reset (async, any time, including mid-handshake): state=IDLE; in_ack=0; core_req=0; core_cmd=IC_NON; core_num=0; core_has_num=0; num_ovf=0; busy=0.
- Codes (unsigned): NON=0x00; ADD..RPAR=0x01..0x06; EQU=0x08; CLR=0x0F; DIGIT d=0x10+d, d=0..9. All other codes are invalid.
- States: IDLE, DECODE, ISSUE, RELEASE.
- IDLE: in_cmd!=NON -> latch into cmd_q, go to DECODE.
- DECODE (1 cycle):
  - digit: num = num*10+d, computed as (num<<3)+(num<<1)+d in CD_N+4 bits. If the result exceeds 2^CD_N-1, num=2^CD_N-1 and num_ovf=1. Once saturated, further digits leave num unchanged. Set has_num=1. Go to RELEASE.
  - ADD..RPAR, EQU, CLR: go to ISSUE.
  - invalid code: dropped, no core traffic. Go to RELEASE.
- ISSUE:
  - core_req=1; core_cmd=cmd_q, core_num and core_has_num held stable until the cycle after core_ack.
  - core_ack=1 sampled: core_req=0 next cycle; num=0, has_num=0, num_ovf=0; go to RELEASE.
  - CLR issues the same way; it carries the pre-clear operand, and the core discards it.
  - No timeout. ISSUE waits indefinitely.
- RELEASE: in_ack=1. When in_cmd==NON, go to IDLE, with in_ack=0 on the same edge.
- Latency: digit key seen at edge 0 -> in_ack high after edge 2. Operator key -> core_req high after edge 2. After core_ack, in_ack rises the next edge.
- in_cmd changes while busy are ignored; only the latched cmd_q is used.
- core_ack while not in ISSUE is ignored.
- Key held across many cycles yields exactly one action (four-phase handshake).
- busy=0 only in IDLE.

Decomposition:
- Shared package/header: command code constants (NON, ADD, SUB, MUL, DIV, LPAR, RPAR, EQU, CLR, DIGIT base), state encoding for IDLE/DECODE/ISSUE/RELEASE, width defaults.
- One natural sub-module: digit_mac. Combinational num*10+d with saturation and an overflow flag out, so it is testable standalone.

Test Plan:
1. Keys 0x11, 0x12, 0x13 with full handshake each, then ADD (0x01). Expect core_req=1, core_cmd=0x01, core_num=123, core_has_num=1. After core_ack: core_num=0, core_has_num=0.
2. CD_N=8: digits 2,5,6. Expect num=255 and num_ovf=1 after the third digit. A further digit 7 leaves num=255. EQU+ack clears num_ovf.
3. EQU (0x08) with no digits. Expect core_has_num=0 and core_num=0. Hold core_ack=0 for 20 cycles: core_req and core_cmd stay stable, in_ack stays 0.
4. Invalid code 0x1C. Expect no core_req, in_ack=1 two cycles later, then IDLE after in_cmd=0. Key 0x14 held 50 cycles gives exactly one digit accumulated.
5. Assert Reset low while in ISSUE with core_req=1. All outputs drop to reset values immediately, without waiting for a clock edge. After Reset returns high, the block is in IDLE with num=0.
6. CLR (0x0F) after digits 9,9. Expect core_cmd=0x0F, core_num=99. After ack: num=0, num_ovf=0.
